spi_frame_ctrl: RTL

Downstream of the SPI slave shift register. Delimits SPI frames (cs low periods) and checks each frame is exactly 128 bits. Routes valid frames to the AES key register or the input-block register, then runs one AES core operation per data frame with a start/done handshake. Holds the 128-bit result for the output/readback path.

---
 rtl/spi_frame_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: checks each cs-low frame is 128 bits, loads the AES key
// frames, then issues one core operation per data frame and holds the result.
module spi_frame_ctrl #(
    parameter int Nk = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [127:0]      spi_data,
    input  logic              core_done,
    input  logic [127:0]      core_out,
    output logic [Nk*32-1:0]  key,
    output logic [127:0]      block_in,
    output logic              core_start,
    output logic [127:0]      result,
    output logic              result_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              frame_err
);
    localparam int unsigned KW  = Nk * 32;
    localparam int unsigned KF  = (KW + 127) / 128;
    localparam int unsigned IW  = $clog2(KF + 1);
    localparam int unsigned REM = KW - 128 * (KF - 1);

    typedef enum logic [1:0] {KEY, DATA, START, WAIT} state_t;

    state_t         state;
    state_t         state_next;
    logic           cs_q;
    logic [8:0]     bit_cnt;
    logic [IW-1:0]  key_idx;
    logic           frame_end;
    logic           frame_ok;
    logic           key_load;
    logic           data_load;
    logic           last_key;

    always_comb begin
        frame_end = !cs_q && cs;
        frame_ok  = frame_end && (bit_cnt == 9'd128);
        key_load  = frame_ok && (state == KEY);
        data_load = frame_ok && (state == DATA);
        last_key  = (key_idx == IW'(KF - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= KEY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_start = 1'b0;
        busy       = 1'b0;
        case (state)
            KEY:   if (key_load && last_key) state_next = DATA;
            DATA:  if (data_load) state_next = START;
            START: begin
                core_start = 1'b1;
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (core_done) state_next = DATA;
            end
            default: state_next = KEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q         <= 1'b1;
            bit_cnt      <= '0;
            key_idx      <= '0;
            key          <= '0;
            key_ready    <= 1'b0;
            block_in     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cs_q      <= cs;
            // Any completed frame not consumed as key or data is rejected,
            // which covers bad lengths and overruns during an operation.
            frame_err <= frame_end && !(key_load || data_load);

            if (frame_end) begin
                bit_cnt <= '0;
            end else if (!cs && bit_cnt != 9'h1FF) begin
                bit_cnt <= bit_cnt + 9'd1;
            end

            if (key_load) begin
                key_idx <= key_idx + IW'(1);
                if (last_key) begin
                    key[REM-1:0] <= spi_data[REM-1:0];
                    key_ready    <= 1'b1;
                end else if (KF > 1) begin
                    key[KW-1 -: 128] <= spi_data;
                end
            end

            if (data_load) begin
                block_in     <= spi_data;
                result_valid <= 1'b0;
            end

            if (state == WAIT && core_done) begin
                result       <= core_out;
                result_valid <= 1'b1;
            end
        end
    end

endmodule
